// File: rtl/saph_pkg.sv
// Shared types for the saph float datapath: IEEE-754 single word and FPU opcode.
package saph_pkg;

  typedef logic [31:0] float_t;

  typedef enum logic {
    FPU_ADD = 1'b0,
    FPU_MUL = 1'b1
  } saph_fpu_op_t;

  function automatic saph_fpu_op_t mode_to_op(input logic mode);
    return mode ? FPU_MUL : FPU_ADD;
  endfunction

endpackage

// File: rtl/saph_float_seq_fifo.sv
// Registered sync FIFO of {float[LANES], last}; no fall-through, flush empties it in one edge.
module saph_float_seq_fifo
  import saph_pkg::*;
#(
  parameter int LANES = 2,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  float_t [LANES-1:0]     push_data_i,
  input  logic                   push_last_i,
  output logic                   full_o,
  input  logic                   pop_i,
  output logic                   valid_o,
  output float_t [LANES-1:0]     data_o,
  output logic                   last_o
);

  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = $clog2(DEPTH + 1);

  typedef struct packed {
    float_t [LANES-1:0] data;
    logic               last;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            push_en, pop_en;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (cnt_q == CNTW'(DEPTH));
  assign valid_o = (cnt_q != '0);
  assign push_en = push_i && !full_o && !flush_i;
  assign pop_en  = pop_i && valid_o && !flush_i;
  assign data_o  = mem_q[rd_ptr_q].data;
  // Gate last so it reads 0 while empty, even before the storage is first written.
  assign last_o  = valid_o && mem_q[rd_ptr_q].last;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push_en) wr_ptr_d = next_ptr(wr_ptr_q);
      if (pop_en)  rd_ptr_d = next_ptr(rd_ptr_q);
      cnt_d = cnt_q + CNTW'(push_en) - CNTW'(pop_en);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= '{data: push_data_i, last: push_last_i};
  end

endmodule

// File: rtl/saph_float_sequencer.sv
// Multi-lane float sequence generator: repeated add/mul of a latched step through a shared FPU.
//   state | meaning
//   IDLE  | ready for start
//   EMIT  | push current term into the output FIFO
//   ISSUE | request next term from the FPU
//   WAIT  | waiting for the FPU result
//   FLUSH | last term queued, waiting for consumer to take it
//   DRAIN | aborted with an FPU op in flight, swallow its result
module saph_float_sequencer
  import saph_pkg::*;
#(
  parameter int LANES = 2,
  parameter int CW    = 8,
  parameter int DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic               mode_i,
  input  logic [CW-1:0]      count_i,
  input  float_t [LANES-1:0] init_i,
  input  float_t [LANES-1:0] step_i,
  input  logic               abort_i,
  output logic               ready_o,
  output logic               done_o,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output float_t [LANES-1:0] out_data_o,
  output logic               out_last_o,
  output logic               fpu_req_valid_o,
  input  logic               fpu_req_ready_i,
  output saph_fpu_op_t       fpu_op_o,
  output float_t [LANES-1:0] fpu_a_o,
  output float_t [LANES-1:0] fpu_b_o,
  input  logic               fpu_res_valid_i,
  input  float_t [LANES-1:0] fpu_res_i
);

  typedef enum logic [2:0] {S_IDLE, S_EMIT, S_ISSUE, S_WAIT, S_FLUSH, S_DRAIN} state_t;

  state_t             state_q, state_d;
  logic               mode_q, mode_d;
  float_t [LANES-1:0] cur_q, cur_d;
  float_t [LANES-1:0] step_q, step_d;
  logic [CW-1:0]      rem_q, rem_d;
  logic               done_q, done_d;
  logic               fifo_push, fifo_full;

  saph_float_seq_fifo #(.LANES(LANES), .DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (abort_i),
    .push_i      (fifo_push),
    .push_data_i (cur_q),
    .push_last_i (rem_q == CW'(1)),
    .full_o      (fifo_full),
    .pop_i       (out_ready_i),
    .valid_o     (out_valid_o),
    .data_o      (out_data_o),
    .last_o      (out_last_o)
  );

  assign ready_o         = (state_q == S_IDLE);
  assign done_o          = done_q;
  assign fpu_req_valid_o = (state_q == S_ISSUE);
  assign fpu_op_o        = mode_to_op(mode_q);
  assign fpu_a_o         = cur_q;
  assign fpu_b_o         = step_q;

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    cur_d     = cur_q;
    step_d    = step_q;
    rem_d     = rem_q;
    done_d    = 1'b0;
    fifo_push = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i && !abort_i) begin
          mode_d = mode_i;
          cur_d  = init_i;
          step_d = step_i;
          rem_d  = count_i;
          if (count_i == '0) done_d  = 1'b1;
          else               state_d = S_EMIT;
        end
      end
      S_EMIT: begin
        if (abort_i) state_d = S_IDLE;
        else if (!fifo_full) begin
          fifo_push = 1'b1;
          rem_d     = rem_q - 1'b1;
          state_d   = (rem_q == CW'(1)) ? S_FLUSH : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (fpu_req_ready_i) state_d = abort_i ? S_DRAIN : S_WAIT;
        else if (abort_i)    state_d = S_IDLE;
      end
      S_WAIT: begin
        // A result landing in the abort cycle is already the in-flight one; nothing left to drain.
        if (fpu_res_valid_i) begin
          state_d = abort_i ? S_IDLE : S_EMIT;
          if (!abort_i) cur_d = fpu_res_i;
        end else if (abort_i) begin
          state_d = S_DRAIN;
        end
      end
      S_FLUSH: begin
        if (abort_i) state_d = S_IDLE;
        else if (out_valid_o && out_ready_i && out_last_o) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (fpu_res_valid_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      mode_q  <= 1'b0;
      cur_q   <= '0;
      step_q  <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cur_q   <= cur_d;
      step_q  <= step_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
    end
  end

endmodule
